// File: rtl/os_sequencer.sv
// os_sequencer: drives the corelet instruction word for one output-stationary run.
// A run loads K activation vectors into L0 and K weight vectors into the IFIFO.
// It then executes K MAC cycles, flushes the array pipeline and drains row
// OFIFO rows into pmem.
// Every inst bit is a register. Buffer-full and ofifo_valid inputs are sampled on the
// clock edge that launches the strobe they gate.
module os_sequencer #(
    parameter int unsigned row    = 8,
    parameter int unsigned col    = 8,
    parameter logic [10:0] w_base = 11'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  k_len,
    input  logic        l0_o_full,
    input  logic        ififo_o_full,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadW,
        StExec,
        StFlush,
        StDrain,
        StDone
    } state_e;

    // CEN/WEN high, everything else low.
    localparam logic [33:0] IdleWord   = {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};
    // Low field: ofifo rd, ififo wr, ififo rd, l0 rd, l0 wr, MAC[1:0].
    localparam logic [6:0]  ExecLow    = 7'b0011010;
    localparam logic [4:0]  FlushLast  = 5'(row + col - 2);
    localparam logic [4:0]  RowN       = 5'(row);
    localparam logic [10:0] PmemLast   = 11'(row - 1);

    state_e      r_state;
    logic [4:0]  r_k;
    logic [4:0]  r_idx;
    logic [4:0]  r_cnt;
    logic [33:0] r_inst;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_len_ok;
    logic        w_rd_now;
    logic        w_pop_now;
    logic        w_wr_now;
    logic        w_pop_ok;
    logic [10:0] w_addr_a;
    logic [10:0] w_addr_w;
    logic [10:0] w_pop_addr;

    // Assemble one instruction word; WEN_xmem is always 1 because xmem is only read.
    function automatic logic [33:0] mk_inst(input logic        cen_p,
                                            input logic        wen_p,
                                            input logic [10:0] a_p,
                                            input logic        cen_x,
                                            input logic [10:0] a_x,
                                            input logic [6:0]  lo);
        return {1'b0, cen_p, wen_p, a_p, cen_x, 1'b1, a_x, lo};
    endfunction

    // Decode of the current registered word and of the length request.
    always_comb begin
        w_len_ok   = (k_len != 5'd0) && (k_len <= 5'd16);
        w_rd_now   = ~r_inst[19];
        w_pop_now  = r_inst[6];
        w_wr_now   = ~r_inst[32];
        w_pop_ok   = ofifo_valid && (r_cnt < RowN);
        w_addr_a   = {6'd0, r_idx};
        w_addr_w   = w_base + {6'd0, r_idx};
        w_pop_addr = {6'd0, r_cnt - 5'd1};
    end

    // Run FSM; every branch loads the word that is issued in the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_k     <= 5'd0;
            r_idx   <= 5'd0;
            r_cnt   <= 5'd0;
            r_inst  <= IdleWord;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_inst <= IdleWord;
                    if (start) begin
                        if (w_len_ok) begin
                            r_k     <= k_len;
                            r_state <= StLoadA;
                            r_busy  <= 1'b1;
                            r_idx   <= {4'd0, ~l0_o_full};
                            r_inst  <= mk_inst(1'b1, 1'b1, 11'd0, l0_o_full, 11'd0, 7'd0);
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StLoadA: begin
                    if (r_idx == r_k) begin
                        // Last A read is in flight: its l0 wr overlaps the first W read.
                        r_state <= StLoadW;
                        r_idx   <= {4'd0, ~ififo_o_full};
                        r_inst  <= mk_inst(1'b1, 1'b1, 11'd0, ififo_o_full, w_base,
                                           {4'b0000, w_rd_now, 2'b00});
                    end else begin
                        r_idx  <= r_idx + {4'd0, ~l0_o_full};
                        r_inst <= mk_inst(1'b1, 1'b1, 11'd0, l0_o_full, w_addr_a,
                                          {4'b0000, w_rd_now, 2'b00});
                    end
                end
                StLoadW: begin
                    if (r_idx == r_k) begin
                        if (w_rd_now) begin
                            // Trailing ififo wr for the final weight read.
                            r_inst <= mk_inst(1'b1, 1'b1, 11'd0, 1'b1, w_addr_w, 7'b0100000);
                        end else begin
                            r_state <= StExec;
                            r_cnt   <= 5'd0;
                            r_inst  <= mk_inst(1'b1, 1'b1, 11'd0, 1'b1, 11'd0, ExecLow);
                        end
                    end else begin
                        r_idx  <= r_idx + {4'd0, ~ififo_o_full};
                        r_inst <= mk_inst(1'b1, 1'b1, 11'd0, ififo_o_full, w_addr_w,
                                          {1'b0, w_rd_now, 5'b00000});
                    end
                end
                StExec: begin
                    if (r_cnt == r_k - 5'd1) begin
                        r_state <= StFlush;
                        r_cnt   <= 5'd0;
                        r_inst  <= IdleWord;
                    end else begin
                        r_cnt  <= r_cnt + 5'd1;
                        r_inst <= mk_inst(1'b1, 1'b1, 11'd0, 1'b1, 11'd0, ExecLow);
                    end
                end
                StFlush: begin
                    if (r_cnt == FlushLast) begin
                        r_state <= StDrain;
                        r_cnt   <= {4'd0, ofifo_valid};
                        r_inst  <= mk_inst(1'b1, 1'b1, 11'd0, 1'b1, 11'd0,
                                           {ofifo_valid, 6'd0});
                    end else begin
                        r_cnt  <= r_cnt + 5'd1;
                        r_inst <= IdleWord;
                    end
                end
                StDrain: begin
                    if (w_wr_now && (r_inst[30:20] == PmemLast)) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                        r_inst  <= IdleWord;
                    end else begin
                        // r_cnt counts pops issued; a write lands one cycle after its pop.
                        r_cnt  <= r_cnt + {4'd0, w_pop_ok};
                        r_inst <= mk_inst(~w_pop_now, ~w_pop_now,
                                          w_pop_now ? w_pop_addr : r_inst[30:20],
                                          1'b1, 11'd0, {w_pop_ok, 6'd0});
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_inst  <= IdleWord;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_inst  <= IdleWord;
                end
            endcase
        end
    end

    assign inst = r_inst;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_os_sequencer.sv
// Bench for os_sequencer: scoreboard queues hold expected xmem read and pmem write
// addresses, popped by a monitor as the DUT issues them; per-run counts checked after done.
module tb_os_sequencer;

    localparam int          ROW = 8;
    localparam int          COL = 8;
    localparam logic [10:0] WB  = 11'd64;
    localparam logic [33:0] IDLE_W = {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  k_len = 5'd0;
    logic        l0_o_full = 1'b0;
    logic        ififo_o_full = 1'b0;
    logic        ofifo_valid = 1'b0;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic        err;

    os_sequencer #(.row(ROW), .col(COL), .w_base(WB)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .k_len        (k_len),
        .l0_o_full    (l0_o_full),
        .ififo_o_full (ififo_o_full),
        .ofifo_valid  (ofifo_valid),
        .inst         (inst),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int q_rd[$];
    int q_pw[$];
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int last_exec = 0;
    int first_pop = -1;
    int n_l0wr = 0, n_ifwr = 0, n_exec = 0, n_pop = 0, n_pw = 0, n_done = 0, n_err = 0;
    logic v_at_edge = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic prep(input int k);
        q_rd.delete();
        q_pw.delete();
        n_l0wr = 0; n_ifwr = 0; n_exec = 0; n_pop = 0; n_pw = 0; n_done = 0; n_err = 0;
        first_pop = -1;
        for (int i = 0; i < k; i++) q_rd.push_back(i);
        for (int i = 0; i < k; i++) q_rd.push_back(int'(WB) + i);
        for (int i = 0; i < ROW; i++) q_pw.push_back(i);
    endtask

    // Called just after a posedge; start is accepted on the next edge.
    task automatic accept(input int k);
        start = 1'b1;
        k_len = 5'(k);
        @(posedge clk);
        start_cyc = cyc;
        #1 start = 1'b0;
    endtask

    task automatic finish_run(input int k, input bit tgl, input bit poke, input int exp_lat);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (tgl) ofifo_valid = ~ofifo_valid;
            if (poke) begin
                start = (i == 3 * k + 6);
                k_len = 5'd5;
            end
            if (n_done > 0) seen = 1'b1;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        repeat (2) @(posedge clk);
        #1;
        check("l0wr_cnt", n_l0wr, k);
        check("ififo_wr_cnt", n_ifwr, k);
        check("exec_cnt", n_exec, k);
        check("pop_cnt", n_pop, ROW);
        check("pmem_wr_cnt", n_pw, ROW);
        check("done_cnt", n_done, 1);
        check("err_cnt", n_err, 0);
        check("rd_left", q_rd.size(), 0);
        check("pw_left", q_pw.size(), 0);
        check("busy_end", busy, 0);
        check("inst_end", inst, IDLE_W);
        if (!tgl) check("flush_len", first_pop - last_exec - 1, ROW + COL - 1);
        if (exp_lat >= 0) check("latency", done_cyc - start_cyc, exp_lat);
    endtask

    always @(posedge clk) v_at_edge <= ofifo_valid;

    // Monitor: one sample per cycle, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        check("acc_zero", inst[33], 0);
        if (!inst[19]) begin
            check("xmem_wen", inst[18], 1);
            check("rd_expected", q_rd.size() > 0, 1);
            if (q_rd.size() > 0) check("rd_addr", inst[17:7], q_rd.pop_front());
        end
        if (!inst[32]) begin
            n_pw++;
            check("pmem_wen", inst[31], 0);
            check("pw_expected", q_pw.size() > 0, 1);
            if (q_pw.size() > 0) check("pw_addr", inst[30:20], q_pw.pop_front());
        end
        if (inst[2]) n_l0wr++;
        if (inst[5]) n_ifwr++;
        if (inst[1:0] == 2'b10 && inst[3] && inst[4]) begin
            n_exec++;
            last_exec = cyc;
        end
        if (inst[6]) begin
            n_pop++;
            check("pop_valid", v_at_edge, 1);
            if (first_pop < 0) first_pop = cyc;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (err) n_err++;
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_inst", inst, IDLE_W);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b1;

        // Nominal K=4: 4+1+4+1+4+15+8+1 cycles counting the start cycle
        @(posedge clk); #1;
        prep(4);
        ofifo_valid = 1'b1;
        accept(4);
        finish_run(4, 1'b0, 1'b0, 38);

        // l0 stall at the second read for two cycles
        @(posedge clk); #1;
        prep(3);
        accept(3);
        l0_o_full = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall1_cen", inst[19], 1);
        check("stall1_addr", inst[17:7], 1);
        @(posedge clk);
        #1 l0_o_full = 1'b0;
        @(negedge clk);
        check("stall2_cen", inst[19], 1);
        check("stall2_addr", inst[17:7], 1);
        finish_run(3, 1'b0, 1'b0, 37);

        // Illegal lengths
        n_err = 0;
        @(posedge clk); #1;
        start = 1'b1; k_len = 5'd0;
        @(posedge clk); #1 start = 1'b0;
        check("err_k0", err, 1);
        check("busy_k0", busy, 0);
        check("inst_k0", inst, IDLE_W);
        @(posedge clk); #1;
        check("err_k0_clr", err, 0);
        start = 1'b1; k_len = 5'd17;
        @(posedge clk); #1 start = 1'b0;
        check("err_k17", err, 1);
        check("busy_k17", busy, 0);
        check("inst_k17", inst, IDLE_W);
        @(posedge clk); #1;
        check("err_k17_clr", err, 0);
        check("err_pulses", n_err, 2);

        // Drain with ofifo_valid toggling every cycle
        prep(2);
        ofifo_valid = 1'b0;
        accept(2);
        finish_run(2, 1'b1, 1'b0, -1);
        ofifo_valid = 1'b1;

        // start pulsed during FLUSH must not disturb the run
        @(posedge clk); #1;
        prep(2);
        accept(2);
        finish_run(2, 1'b0, 1'b1, 32);

        // Reset in the second EXEC cycle, then a K=1 run right after release
        @(posedge clk); #1;
        prep(4);
        accept(4);
        for (int i = 0; i < 100 && n_exec < 1; i++) @(posedge clk);
        check("exec_reached", n_exec, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_inst", inst, IDLE_W);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        prep(1);
        reset = 1'b1;
        accept(1);
        finish_run(1, 1'b0, 1'b0, 29);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
